dual_port_ram_bytewise: RTL and testbench
=========================================

Name: dual_port_ram_bytewise

Overview:
Parametrised true dual-port RAM: two independent read/write ports on one clock, with per-byte write enables and a selectable read latency of 1 or 2. Defined read-during-write and write-write collision rules, plus a collision flag. Optional post-reset clear sequencer fills the array with INIT_VALUE before accepting accesses. Serves as the general-purpose on-chip storage primitive for register files, buffers and FIFOs.

Parameters:
DATA_WIDTH, 16, word width; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
ADDR_WIDTH, 6, address bits; depth = 2**ADDR_WIDTH
READ_LATENCY, 1, 1 or 2 cycles from read_en to data_valid
RDW_MODE, 0, same-port read-during-write: 0 = old data, 1 = new data (byte-merged)
CLEAR_ON_RESET, 1, 1 = sweep array with INIT_VALUE after reset
INIT_VALUE, 0, DATA_WIDTH-bit clear value

Ports:
clk  in  1  single clock for both ports
rst  in  1  synchronous, active-high reset
busy  out  1  high while reset or clear sweep in progress; accesses ignored
collision  out  1  one-cycle pulse: both ports wrote an overlapping byte of one address
port_a_addr  in  ADDR_WIDTH  port A address
port_a_data_in  in  DATA_WIDTH  port A write data
port_a_write_en  in  NUM_BYTES  port A byte write mask
port_a_read_en  in  1  port A read request
port_a_data_out  out  DATA_WIDTH  port A read data
port_a_data_valid  out  1  port A read data valid
port_b_*  same set as port A

Behaviour:
- Reset (rst high): busy=1, data_out=0, data_valid=0, collision=0, clear counter=0. Array contents not reset by rst itself.
- FSM states: RESET, CLEAR, RUN. While rst high: RESET. rst falls -> CLEAR if CLEAR_ON_RESET else RUN.
- CLEAR: one word per cycle, address 0..2**ADDR_WIDTH-1, all bytes written with INIT_VALUE. After the last address -> RUN. busy drops on the first RUN cycle (default depth: 64 CLEAR cycles). rst mid-sweep restarts at address 0.
- RUN: busy=0.
- Any access while busy is discarded; no data_valid is produced.
- Write: byte i of mem[addr] <= data_in[i*BYTE_WIDTH +: BYTE_WIDTH] when write_en[i]=1. Takes effect at the clock edge.
- Read:
  - READ_LATENCY=1: data_out/data_valid registered at the edge after read_en.
  - READ_LATENCY=2: one extra output register stage; valid is pipelined alongside the data.
  - data_valid=0 in cycles with no read result.
  - data_out holds its last value when no read result is produced.
- Same-port read+write, same address:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the word with written bytes replaced by data_in.
- Cross-port read of an address written by the other port in the same cycle always returns the old word.
- Write-write, same address, same cycle:
  - Bytes enabled on A take A's data.
  - Bytes enabled only on B take B's data.
  - collision=1 in the following cycle if any byte overlaps, else 0.
- Different addresses: fully independent, no interaction.
- Address is unsigned; no wrap or bounds logic needed since depth = 2**ADDR_WIDTH.
- Elaboration error if DATA_WIDTH % BYTE_WIDTH != 0 or READ_LATENCY not in {1,2}.

Decomposition:
- Package dpram_pkg:
  - fsm state enum (RESET, CLEAR, RUN)
  - RDW_MODE encoding constants (RDW_OLD=0, RDW_NEW=1)
  - byte-merge function (old word, new word, mask)
- Sub-module dpram_read_pipe: per-port output stage. Handles the RDW merge, READ_LATENCY registers and valid tracking; instantiated twice.
- Top level owns the array, write arbitration, collision flag and clear FSM.

Test Plan:
- Clear sweep: INIT_VALUE=16'hA5A5. Release rst -> busy stays high exactly 64 cycles; then reads of addresses 0, 31, 63 return 16'hA5A5, valid 1 cycle after read_en.
- Byte writes: A writes 16'h1234, mask 2'b11, to addr 5; then 16'hFF00, mask 2'b10 -> A read returns 16'hFF34.
- Read-during-write at addr 7 (old 16'h0001, new 16'h0002): RDW_MODE=0 returns 16'h0001; RDW_MODE=1 returns 16'h0002. Port B reading addr 7 in the same cycle returns 16'h0001 in both modes.
- Write-write collision at addr 9: A writes 16'hAAAA mask 2'b01, B writes 16'hBBBB mask 2'b11 -> mem = 16'hBBAA, collision pulses 1 cycle. Same stimulus with A mask 2'b00 -> no collision.
- READ_LATENCY=2: back-to-back reads of addresses 1, 2, 3 -> three consecutive valid words starting 2 cycles after the first read_en, in order.
- rst reasserted at clear address 20 -> sweep restarts at address 0, busy high for a further 64 cycles after release; accesses issued while busy produce no data_valid.

Source files
------------

// File: rtl/dpram_pkg.sv
// -----------------------------------------------------------------------------
// dpram_pkg
// Shared types and helpers for the byte-writable dual-port RAM.
//   - dpram_state_e : controller states (reset hold, clear sweep, normal run)
//   - RDW_OLD/RDW_NEW : same-port read-during-write selection
//   - byte_merge    : replaces the masked bytes of a word with new data
// -----------------------------------------------------------------------------
package dpram_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2
   } dpram_state_e;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Widest word the merge helper handles; callers size-cast in and out.
   localparam int MAX_WIDTH = 1024;

   // Bit i takes new_word when the byte lane containing bit i is enabled.
   function automatic logic [MAX_WIDTH-1:0] byte_merge(
      input logic [MAX_WIDTH-1:0] old_word,
      input logic [MAX_WIDTH-1:0] new_word,
      input logic [MAX_WIDTH-1:0] byte_mask,
      input int                   byte_width
   );
      logic [MAX_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         if (byte_mask[i / byte_width]) begin
            merged[i] = new_word[i];
         end else begin
            merged[i] = old_word[i];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/dpram_read_pipe.sv
// -----------------------------------------------------------------------------
// dpram_read_pipe
// Per-port read output stage: same-port read-during-write merge, one or two
// output register stages, and a valid flag pipelined alongside the data.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_read_en     : accepted read request (already gated by the controller)
//   i_mem_word    : current array word at this port's address (pre-write)
//   i_wr_data     : this port's write data
//   i_wr_mask     : this port's accepted byte write mask
//   o_data        : read data, holds last value when no result is produced
//   o_valid       : read data valid
// -----------------------------------------------------------------------------
module dpram_read_pipe #(
   parameter int DATA_WIDTH   = 16,
   parameter int BYTE_WIDTH   = 8,
   parameter int READ_LATENCY = 1,
   parameter int RDW_MODE     = 0,
   localparam int NUM_BYTES   = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_read_en,
   input  logic [DATA_WIDTH-1:0] i_mem_word,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [NUM_BYTES-1:0]  i_wr_mask,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid
);
   import dpram_pkg::*;

   logic [NUM_BYTES-1:0]  w_rdw_mask;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic [DATA_WIDTH-1:0] r_s1_data;
   logic                  r_s1_valid;

   // Select old or byte-merged new word for a same-port read-during-write.
   always_comb begin
      w_rdw_mask = {NUM_BYTES{1'b0}};
      if (RDW_MODE == RDW_NEW) begin
         w_rdw_mask = i_wr_mask;
      end else begin
         w_rdw_mask = {NUM_BYTES{1'b0}};
      end
      w_rd_word = DATA_WIDTH'(byte_merge(MAX_WIDTH'(i_mem_word),
                                         MAX_WIDTH'(i_wr_data),
                                         MAX_WIDTH'(w_rdw_mask),
                                         BYTE_WIDTH));
   end

   // First output stage: captures read word, data held when no read.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= {DATA_WIDTH{1'b0}};
      end else begin
         r_s1_valid <= i_read_en;
         if (i_read_en) begin
            r_s1_data <= w_rd_word;
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_s2_data;
      logic                  r_s2_valid;

      // Second output stage: data only advances together with its valid.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= {DATA_WIDTH{1'b0}};
         end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_data <= r_s1_data;
            end
         end
      end

      assign o_data  = r_s2_data;
      assign o_valid = r_s2_valid;
   end else begin : g_lat1
      assign o_data  = r_s1_data;
      assign o_valid = r_s1_valid;
   end

endmodule

// File: rtl/dual_port_ram_bytewise.sv
// -----------------------------------------------------------------------------
// dual_port_ram_bytewise
// True dual-port RAM, single clock, per-byte write enables, read latency 1/2,
// defined read-during-write and write-write collision behaviour, optional
// post-reset clear sweep filling the array with INIT_VALUE.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   busy                : high during reset/clear; accesses are dropped
//   collision           : pulse, both ports wrote a common byte of one address
//   port_x_addr         : address (x = a, b)
//   port_x_data_in      : write data
//   port_x_write_en     : byte write mask
//   port_x_read_en      : read request
//   port_x_data_out     : read data
//   port_x_data_valid   : read data valid
// -----------------------------------------------------------------------------
module dual_port_ram_bytewise #(
   parameter int DATA_WIDTH     = 16,
   parameter int BYTE_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 6,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}},
   localparam int NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  busy,
   output logic                  collision,
   input  logic [ADDR_WIDTH-1:0] port_a_addr,
   input  logic [DATA_WIDTH-1:0] port_a_data_in,
   input  logic [NUM_BYTES-1:0]  port_a_write_en,
   input  logic                  port_a_read_en,
   output logic [DATA_WIDTH-1:0] port_a_data_out,
   output logic                  port_a_data_valid,
   input  logic [ADDR_WIDTH-1:0] port_b_addr,
   input  logic [DATA_WIDTH-1:0] port_b_data_in,
   input  logic [NUM_BYTES-1:0]  port_b_write_en,
   input  logic                  port_b_read_en,
   output logic [DATA_WIDTH-1:0] port_b_data_out,
   output logic                  port_b_data_valid
);
   import dpram_pkg::*;

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
      $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
   end

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   dpram_state_e          r_state;
   logic [ADDR_WIDTH-1:0] r_clr_addr;
   logic                  r_busy;
   logic                  r_collision;

   logic                  w_accept;
   logic                  w_clear_we;
   logic [NUM_BYTES-1:0]  w_a_mask;
   logic [NUM_BYTES-1:0]  w_b_mask;
   logic                  w_a_rd;
   logic                  w_b_rd;
   logic [DATA_WIDTH-1:0] w_a_mem_word;
   logic [DATA_WIDTH-1:0] w_b_mem_word;

   // Gate all port activity: only RUN accepts, and never on a reset edge.
   always_comb begin
      w_accept   = (r_state == ST_RUN) && !rst;
      w_clear_we = (r_state == ST_CLEAR) && !rst;
      if (w_accept) begin
         w_a_mask = port_a_write_en;
         w_b_mask = port_b_write_en;
         w_a_rd   = port_a_read_en;
         w_b_rd   = port_b_read_en;
      end else begin
         w_a_mask = {NUM_BYTES{1'b0}};
         w_b_mask = {NUM_BYTES{1'b0}};
         w_a_rd   = 1'b0;
         w_b_rd   = 1'b0;
      end
      w_a_mem_word = r_mem[port_a_addr];
      w_b_mem_word = r_mem[port_b_addr];
   end

   // Controller: reset hold, one-word-per-cycle clear sweep, then run.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_RESET;
         r_clr_addr <= {ADDR_WIDTH{1'b0}};
         r_busy     <= 1'b1;
      end else begin
         case (r_state)
            ST_RESET: begin
               r_clr_addr <= {ADDR_WIDTH{1'b0}};
               if (CLEAR_ON_RESET != 0) begin
                  r_state <= ST_CLEAR;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b0;
               end
            end
            ST_CLEAR: begin
               if (r_clr_addr == LAST_ADDR) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b0;
               end else begin
                  r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
                  r_busy     <= 1'b1;
               end
            end
            ST_RUN: begin
               r_busy <= 1'b0;
            end
            default: begin
               r_state    <= ST_RESET;
               r_clr_addr <= {ADDR_WIDTH{1'b0}};
               r_busy     <= 1'b1;
            end
         endcase
      end
   end

   // Collision flag: same address and at least one byte enabled on both ports.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_collision <= 1'b0;
      end else begin
         r_collision <= (port_a_addr == port_b_addr) && (|(w_a_mask & w_b_mask));
      end
   end

   // Array writes. Port A is issued after port B so A wins overlapping bytes;
   // bytes enabled only on B keep B's data.
   always_ff @(posedge clk) begin
      if (w_clear_we) begin
         r_mem[r_clr_addr] <= INIT_VALUE;
      end else begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (w_b_mask[i]) begin
               r_mem[port_b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                  port_b_data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (w_a_mask[i]) begin
               r_mem[port_a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                  port_a_data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Each port merges only its own write; the other port's write is never
   // visible in the same cycle, giving old-data cross-port reads.
   dpram_read_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .BYTE_WIDTH   (BYTE_WIDTH),
      .READ_LATENCY (READ_LATENCY),
      .RDW_MODE     (RDW_MODE)
   ) u_read_pipe_a (
      .clk        (clk),
      .rst        (rst),
      .i_read_en  (w_a_rd),
      .i_mem_word (w_a_mem_word),
      .i_wr_data  (port_a_data_in),
      .i_wr_mask  (w_a_mask),
      .o_data     (port_a_data_out),
      .o_valid    (port_a_data_valid)
   );

   dpram_read_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .BYTE_WIDTH   (BYTE_WIDTH),
      .READ_LATENCY (READ_LATENCY),
      .RDW_MODE     (RDW_MODE)
   ) u_read_pipe_b (
      .clk        (clk),
      .rst        (rst),
      .i_read_en  (w_b_rd),
      .i_mem_word (w_b_mem_word),
      .i_wr_data  (port_b_data_in),
      .i_wr_mask  (w_b_mask),
      .o_data     (port_b_data_out),
      .o_valid    (port_b_data_valid)
   );

   assign busy      = r_busy;
   assign collision = r_collision;

endmodule

// File: tb/tb_dual_port_ram_bytewise.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_bytewise
// Three instances share one stimulus stream:
//   u_dut0 : latency 1, old-data read-during-write
//   u_dut1 : latency 1, new-data read-during-write
//   u_dut2 : latency 2, old-data read-during-write
// All clear to 16'hA5A5. Inputs change and outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_bytewise;
   localparam int DW = 16;
   localparam int AW = 6;
   localparam int NB = 2;
   localparam logic [DW-1:0] INIT = 16'hA5A5;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_din, b_din;
   logic [NB-1:0] a_we, b_we;
   logic          a_re, b_re;

   logic          busy0, busy1, busy2;
   logic          col0, col1, col2;
   logic [DW-1:0] a_dout0, a_dout1, a_dout2, b_dout0, b_dout1, b_dout2;
   logic          a_val0, a_val1, a_val2, b_val0, b_val1, b_val2;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   dual_port_ram_bytewise #(.READ_LATENCY(1), .RDW_MODE(0), .INIT_VALUE(INIT)) u_dut0 (
      .clk(clk), .rst(rst), .busy(busy0), .collision(col0),
      .port_a_addr(a_addr), .port_a_data_in(a_din), .port_a_write_en(a_we),
      .port_a_read_en(a_re), .port_a_data_out(a_dout0), .port_a_data_valid(a_val0),
      .port_b_addr(b_addr), .port_b_data_in(b_din), .port_b_write_en(b_we),
      .port_b_read_en(b_re), .port_b_data_out(b_dout0), .port_b_data_valid(b_val0)
   );

   dual_port_ram_bytewise #(.READ_LATENCY(1), .RDW_MODE(1), .INIT_VALUE(INIT)) u_dut1 (
      .clk(clk), .rst(rst), .busy(busy1), .collision(col1),
      .port_a_addr(a_addr), .port_a_data_in(a_din), .port_a_write_en(a_we),
      .port_a_read_en(a_re), .port_a_data_out(a_dout1), .port_a_data_valid(a_val1),
      .port_b_addr(b_addr), .port_b_data_in(b_din), .port_b_write_en(b_we),
      .port_b_read_en(b_re), .port_b_data_out(b_dout1), .port_b_data_valid(b_val1)
   );

   dual_port_ram_bytewise #(.READ_LATENCY(2), .RDW_MODE(0), .INIT_VALUE(INIT)) u_dut2 (
      .clk(clk), .rst(rst), .busy(busy2), .collision(col2),
      .port_a_addr(a_addr), .port_a_data_in(a_din), .port_a_write_en(a_we),
      .port_a_read_en(a_re), .port_a_data_out(a_dout2), .port_a_data_valid(a_val2),
      .port_b_addr(b_addr), .port_b_data_in(b_din), .port_b_write_en(b_we),
      .port_b_read_en(b_re), .port_b_data_out(b_dout2), .port_b_data_valid(b_val2)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle();
      a_we = 2'b00;
      b_we = 2'b00;
      a_re = 1'b0;
      b_re = 1'b0;
   endtask

   // Port A read, checked on the latency-1 and latency-2 instances.
   task automatic rd_a(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string tag);
      a_addr = addr;
      a_re   = 1'b1;
      step();
      a_re = 1'b0;
      chk_eq({tag, "_l1_valid"}, 32'(a_val0), 32'd1);
      chk_eq({tag, "_l1_data"}, 32'(a_dout0), 32'(exp));
      chk_eq({tag, "_l2_early"}, 32'(a_val2), 32'd0);
      step();
      chk_eq({tag, "_l2_valid"}, 32'(a_val2), 32'd1);
      chk_eq({tag, "_l2_data"}, 32'(a_dout2), 32'(exp));
      chk_eq({tag, "_l1_drop"}, 32'(a_val0), 32'd0);
   endtask

   initial begin
      logic [DW-1:0] wd [1:3];
      int            cnt;
      logic          seen_valid;

      wd[1] = 16'h1111;
      wd[2] = 16'h2222;
      wd[3] = 16'h3333;

      rst    = 1'b1;
      a_addr = 6'd0;
      b_addr = 6'd0;
      a_din  = 16'h0000;
      b_din  = 16'h0000;
      idle();
      repeat (3) step();
      chk_eq("rst_busy", 32'(busy0), 32'd1);
      chk_eq("rst_valid", 32'(a_val0), 32'd0);
      chk_eq("rst_dout", 32'(a_dout0), 32'd0);
      chk_eq("rst_collision", 32'(col0), 32'd0);
      chk_eq("rst_l2_dout", 32'(a_dout2), 32'd0);

      // Clear sweep duration after release.
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (busy0) cnt++;
         else break;
      end
      chk_eq("clr_busy_cycles", 32'(cnt), 32'd64);
      chk_eq("clr_busy_l2", 32'(busy2), 32'd0);

      rd_a(6'd0, INIT, "clr_a0");
      rd_a(6'd31, INIT, "clr_a31");
      rd_a(6'd63, INIT, "clr_a63");

      // Byte writes.
      a_addr = 6'd5; a_din = 16'h1234; a_we = 2'b11;
      step();
      a_din = 16'hFF00; a_we = 2'b10;
      step();
      idle();
      rd_a(6'd5, 16'hFF34, "bytewr");

      // Read-during-write at address 7, with a cross-port read.
      a_addr = 6'd7; a_din = 16'h0001; a_we = 2'b11;
      step();
      a_din = 16'h0002; a_we = 2'b11; a_re = 1'b1;
      b_addr = 6'd7; b_re = 1'b1;
      step();
      idle();
      chk_eq("rdw_old_a", 32'(a_dout0), 32'h0001);
      chk_eq("rdw_new_a", 32'(a_dout1), 32'h0002);
      chk_eq("rdw_new_valid", 32'(a_val1), 32'd1);
      chk_eq("rdw_old_b", 32'(b_dout0), 32'h0001);
      chk_eq("rdw_new_b", 32'(b_dout1), 32'h0001);
      step();
      chk_eq("rdw_l2_a", 32'(a_dout2), 32'h0001);
      chk_eq("rdw_l2_b", 32'(b_dout2), 32'h0001);
      rd_a(6'd7, 16'h0002, "rdw_after");

      // Write-write collision at address 9.
      a_addr = 6'd9; a_din = 16'hAAAA; a_we = 2'b01;
      b_addr = 6'd9; b_din = 16'hBBBB; b_we = 2'b11;
      step();
      idle();
      chk_eq("coll_pulse", 32'(col0), 32'd1);
      step();
      chk_eq("coll_drop", 32'(col0), 32'd0);
      rd_a(6'd9, 16'hBBAA, "coll_data");
      a_din = 16'hAAAA; a_we = 2'b00;
      b_din = 16'hBBBB; b_we = 2'b11;
      step();
      idle();
      chk_eq("nocoll", 32'(col0), 32'd0);
      rd_a(6'd9, 16'hBBBB, "nocoll_data");

      // Independent writes on both ports, then back-to-back reads.
      a_addr = 6'd1; a_din = 16'h1111; a_we = 2'b11;
      b_addr = 6'd2; b_din = 16'h2222; b_we = 2'b11;
      step();
      a_addr = 6'd3; a_din = 16'h3333; a_we = 2'b11;
      b_we = 2'b00;
      step();
      idle();
      for (int c = 0; c < 6; c++) begin
         if (c >= 1) begin
            chk_eq($sformatf("b2b_l1_valid_%0d", c), 32'(a_val0), (c <= 3) ? 32'd1 : 32'd0);
            chk_eq($sformatf("b2b_l1_data_%0d", c), 32'(a_dout0),
                   (c <= 3) ? 32'(wd[c]) : 32'h3333);
            chk_eq($sformatf("b2b_l2_valid_%0d", c), 32'(a_val2),
                   (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
            if (c >= 2) begin
               chk_eq($sformatf("b2b_l2_data_%0d", c), 32'(a_dout2),
                      (c <= 4) ? 32'(wd[c-1]) : 32'h3333);
            end
         end
         if (c < 3) begin
            a_addr = 6'(c + 1);
            a_re   = 1'b1;
         end else begin
            a_re = 1'b0;
         end
         if (c < 5) step();
      end

      // Reset reasserted mid-sweep.
      a_addr = 6'd0;  a_din = 16'h0BAD; a_we = 2'b11;
      b_addr = 6'd40; b_din = 16'h4040; b_we = 2'b11;
      step();
      idle();
      rd_a(6'd40, 16'h4040, "pre_rst");
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      repeat (21) step();
      chk_eq("busy_mid_sweep", 32'(busy0), 32'd1);
      rst = 1'b1;
      repeat (2) step();
      rst    = 1'b0;
      a_addr = 6'd40; a_re = 1'b1;
      b_addr = 6'd0;  b_re = 1'b1;
      cnt        = 0;
      seen_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (a_val0 | b_val0 | a_val2 | b_val2) seen_valid = 1'b1;
         if (busy0) cnt++;
         else break;
      end
      idle();
      repeat (2) begin
         step();
         if (a_val0 | b_val0 | a_val2 | b_val2) seen_valid = 1'b1;
      end
      chk_eq("restart_busy_cycles", 32'(cnt), 32'd64);
      chk_eq("busy_no_valid", 32'(seen_valid), 32'd0);
      rd_a(6'd0, INIT, "restart_a0");
      rd_a(6'd40, INIT, "restart_a40");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
